// File: rtl/arm_fetch_pkg.sv
// arm_fetch_pkg: shared fetch-unit definitions.
//   RESET_VECTOR  - default first fetch address after reset
//   fetch_state_e - fetch FSM state encodings
//   word_align()  - clears the byte-offset bits of an address
package arm_fetch_pkg;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   typedef enum logic [1:0] {FETCH_IDLE, FETCH_REQ, FETCH_DROP} fetch_state_e;
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/arm_fetch_if.sv
// arm_fetch_if: fetch unit bus bundle.
//   imem_*            - instruction memory req/ack read port
//   inst_*            - valid/ready instruction stream to the decoder
//   pc_we/pc_in       - redirect from the decoder
//   halted            - core halted, level-sensitive
// master = fetch unit, slave = memory/decoder side.
interface arm_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        pc_we;
   logic [31:0] pc_in;
   logic        halted;
   modport master (output imem_req, imem_addr, inst_valid, inst, inst_pc,
                   input  imem_ack, imem_rdata, inst_ready, pc_we, pc_in, halted);
   modport slave  (input  imem_req, imem_addr, inst_valid, inst, inst_pc,
                   output imem_ack, imem_rdata, inst_ready, pc_we, pc_in, halted);
endinterface

// File: rtl/arm_fetch_fifo.sv
// arm_fetch_fifo: synchronous prefetch FIFO of {pc, inst} entries.
//   clk, rst_b  - clock, async active-low reset
//   push/din    - write an entry
//   pop/dout    - advance the head; dout is the current head
//   flush       - empty the FIFO; wins over push and pop
//   full, empty, count - occupancy
module arm_fetch_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [63:0]              din,
   output logic [63:0]              dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [63:0]   mem_q [DEPTH];
   logic [63:0]   mem_d [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;
   assign full    = cnt_q == CW'(DEPTH);
   assign empty   = cnt_q == '0;
   assign count   = cnt_q;
   assign dout    = mem_q[rd_q];
   assign do_push = push && !flush && !full;
   assign do_pop  = pop && !flush && !empty;
   always_comb begin
      mem_d = mem_q;
      if (do_push) mem_d[wr_q] = din;
      wr_d  = flush ? '0 : wr_q + AW'(do_push);
      rd_d  = flush ? '0 : rd_q + AW'(do_pop);
      cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
   end
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         mem_q <= '{default: '0};
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/arm_fetch.sv
// arm_fetch: instruction fetch unit with prefetch FIFO and PC redirect.
//   clk, rst_b - clock, async active-low reset
//   bus        - arm_fetch_if.master: imem req/ack port, decoder
//                valid/ready stream, redirect and halt inputs
module arm_fetch
   import arm_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_VECTOR,
   parameter int          DEPTH    = 2
) (
   input  logic       clk,
   input  logic       rst_b,
   arm_fetch_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d, addr_q, addr_d, nxt_addr;
   logic          ack, push, pop, full, empty;
   logic [CW-1:0] count, count_nxt;
   logic [63:0]   head;
   assign ack      = bus.imem_ack && state_q != FETCH_IDLE;
   assign push     = ack && state_q == FETCH_REQ && !bus.pc_we;
   assign pop      = bus.inst_valid && bus.inst_ready && !bus.pc_we;
   // occupancy after this edge's push/pop, used to chain back-to-back requests
   assign count_nxt = count + CW'(push) - CW'(pop);
   assign nxt_addr  = addr_q + 32'd4;
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      if (bus.pc_we) fetch_pc_d = word_align(bus.pc_in);
      case (state_q)
         FETCH_IDLE:
            if (!bus.halted && !bus.pc_we && !full) begin
               state_d = FETCH_REQ;
               addr_d  = fetch_pc_q;
            end
         FETCH_REQ:
            // a redirect never aborts the handshake; it only discards the reply
            if (bus.pc_we) state_d = ack ? FETCH_IDLE : FETCH_DROP;
            else if (ack) begin
               fetch_pc_d = nxt_addr;
               if (!bus.halted && count_nxt < CW'(DEPTH)) addr_d = nxt_addr;
               else state_d = FETCH_IDLE;
            end
         FETCH_DROP:
            if (ack) state_d = FETCH_IDLE;
         default: state_d = FETCH_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= FETCH_IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
      end
   end
   arm_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_b (rst_b),
      .push  (push),
      .pop   (pop),
      .flush (bus.pc_we),
      .din   ({addr_q, bus.imem_rdata}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   assign bus.imem_req   = state_q != FETCH_IDLE;
   assign bus.imem_addr  = addr_q;
   assign bus.inst_valid = !empty && !bus.halted;
   assign bus.inst_pc    = head[63:32];
   assign bus.inst       = head[31:0];
endmodule
